l1a_tag_fifo: RTL

//  Upstream feeder of the L1A checker FSM. Counts L1As and writes one 4-word tag record per L1A into an internal FIFO.
//  The checker pops the records word-by-word (READ_ENA) and latches the words with its B4/L1L/L1H/B5 enables.

---
 rtl/l1a_tag_fifo.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/l1a_tag_fifo.sv
// l1a_tag_fifo: counts L1A strobes and writes one 4-word tag record per L1A
// into an internal word FIFO. The downstream L1A checker pops the FIFO one
// 16-bit word per READ_ENA and uses MT/LAST to track record boundaries.
//
// Record layout (tag = L1A_CNT after increment):
//   W0 = {8'hB4, 7'b0, match}
//   W1 = {4'h1, tag[11:0]}
//   W2 = {4'h2, tag[23:12]}
//   W3 = {8'hB5, byte3}
// Build option: define L1A_TAG_CHKSUM_EN to make byte3 a byte-XOR checksum of
// W0..W2 (with 8'hB4); otherwise byte3 is an 8-bit record sequence number.
//
// Ports:
//   CLK, RST       clock, asynchronous active-high reset
//   L1A, L1A_MATCH one-cycle L1A strobe and its trigger-match flag
//   CLR_CNT        synchronous clear of L1A counter and sequence number
//   READ_ENA       pop one word; DOUT valid the following cycle
//   DOUT           last popped word (held until the next pop)
//   MT, LAST, FULL FIFO holds 0 / <=4 / >(capacity-4) words
//   OVFL, UNDFL    sticky: record dropped / pop while empty
//   L1A_CNT        running 24-bit L1A count
module l1a_tag_fifo #(
  parameter int unsigned DEPTH_REC = 16,
  parameter int unsigned PEND_MAX  = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        L1A,
  input  logic        L1A_MATCH,
  input  logic        CLR_CNT,
  input  logic        READ_ENA,
  output logic [15:0] DOUT,
  output logic        MT,
  output logic        LAST,
  output logic        FULL,
  output logic        OVFL,
  output logic        UNDFL,
  output logic [23:0] L1A_CNT
);

  localparam int unsigned NW         = 4 * DEPTH_REC;
  localparam int unsigned AW         = $clog2(NW);
  localparam int unsigned PW         = $clog2(PEND_MAX + 1);
  localparam int unsigned FULL_LIM_I = NW - 4;
  localparam int unsigned LAST_LIM_I = 4;
  localparam int unsigned PEND_MAX_I = PEND_MAX;
  localparam logic [AW:0]   FULL_LIM = FULL_LIM_I[AW:0];
  localparam logic [AW:0]   LAST_LIM = LAST_LIM_I[AW:0];
  localparam logic [PW-1:0] PEND_TOP = PEND_MAX_I[PW-1:0];

  typedef enum logic [2:0] {W_IDLE, W0, W1, W2, W3} wstate_t;

  wstate_t       state, state_n;
  logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, count, count_n;
  logic [15:0]   mem [NW];
  logic [23:0]   l1a_cnt_q, tag_new, rec_tag;
  logic          rec_match;
  logic [PW-1:0] pend, push_idx;
  logic [23:0]   q_tag   [PEND_MAX];
  logic          q_match [PEND_MAX];
  logic          take, pop, push, drop, skip, wr_en, rd_ok;
  logic [15:0]   wr_data;
  logic [7:0]    byte3;

  assign tag_new = l1a_cnt_q + 24'd1;
  assign count   = wr_ptr - rd_ptr;
  assign L1A_CNT = l1a_cnt_q;

  // CLR_CNT has priority; a simultaneous L1A still uses tag_new (pre-clear + 1).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          l1a_cnt_q <= '0;
    else if (CLR_CNT) l1a_cnt_q <= '0;
    else if (L1A)     l1a_cnt_q <= tag_new;
  end

  // Writer next-state / control
  always_comb begin
    state_n = state;
    take    = 1'b0;
    wr_en   = 1'b0;
    skip    = 1'b0;
    case (state)
      W_IDLE: if (L1A || pend != '0) begin
        take    = 1'b1;
        state_n = W0;
      end
      W0: begin
        // Whole-record space check; never start a record that cannot finish.
        if (count > FULL_LIM) begin
          skip    = 1'b1;
          state_n = W_IDLE;
        end else begin
          wr_en   = 1'b1;
          state_n = W1;
        end
      end
      W1: begin
        wr_en   = 1'b1;
        state_n = W2;
      end
      W2: begin
        wr_en   = 1'b1;
        state_n = W3;
      end
      W3: begin
        wr_en = 1'b1;
        if (L1A || pend != '0) begin
          take    = 1'b1;
          state_n = W0;
        end else begin
          state_n = W_IDLE;
        end
      end
      default: state_n = W_IDLE;
    endcase
  end

  // Pending-L1A queue: holds tag/match of L1As that arrived mid-record so
  // each later record carries its own L1A's values. The oldest entry is
  // consumed first; a fresh L1A is consumed directly only when nothing waits.
  always_comb begin
    pop      = take && (pend != '0);
    push     = 1'b0;
    drop     = 1'b0;
    push_idx = pop ? pend - PW'(1) : pend;
    if (L1A && !(take && pend == '0)) begin
      if (pop)                  push = 1'b1;
      else if (pend == PEND_TOP) drop = 1'b1;
      else                      push = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= W_IDLE;
      rec_tag   <= '0;
      rec_match <= 1'b0;
      pend      <= '0;
      OVFL      <= 1'b0;
      for (int unsigned i = 0; i < PEND_MAX; i++) begin
        q_tag[i]   <= '0;
        q_match[i] <= 1'b0;
      end
    end else begin
      state <= state_n;
      pend  <= pend + PW'(push) - PW'(pop);
      if (take) begin
        rec_tag   <= pop ? q_tag[0]   : tag_new;
        rec_match <= pop ? q_match[0] : L1A_MATCH;
      end
      if (pop) begin
        for (int unsigned i = 0; i + 1 < PEND_MAX; i++) begin
          q_tag[i]   <= q_tag[i+1];
          q_match[i] <= q_match[i+1];
        end
      end
      if (push) begin
        q_tag[push_idx]   <= tag_new;
        q_match[push_idx] <= L1A_MATCH;
      end
      if (drop || skip) OVFL <= 1'b1;
    end
  end

`ifdef L1A_TAG_CHKSUM_EN
  assign byte3 = {7'b0, rec_match} ^ rec_tag[7:0] ^ {4'h1, rec_tag[11:8]}
               ^ rec_tag[19:12] ^ {4'h2, rec_tag[23:20]} ^ 8'hB4;
`else
  logic [7:0] seq;

  // Advances once per record actually written (its W3 cycle).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)              seq <= '0;
    else if (CLR_CNT)     seq <= '0;
    else if (state == W3) seq <= seq + 8'd1;
  end

  assign byte3 = seq;
`endif

  always_comb begin
    wr_data = '0;
    case (state)
      W0:      wr_data = {8'hB4, 7'b0, rec_match};
      W1:      wr_data = {4'h1, rec_tag[11:0]};
      W2:      wr_data = {4'h2, rec_tag[23:12]};
      W3:      wr_data = {8'hB5, byte3};
      default: wr_data = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_ok    = READ_ENA && (count != '0);
  assign wr_ptr_n = wr_ptr + {{AW{1'b0}}, wr_en};
  assign rd_ptr_n = rd_ptr + {{AW{1'b0}}, rd_ok};
  assign count_n  = wr_ptr_n - rd_ptr_n;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      DOUT   <= '0;
      MT     <= 1'b1;
      LAST   <= 1'b1;
      FULL   <= 1'b0;
      UNDFL  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      if (rd_ok) DOUT <= mem[rd_ptr[AW-1:0]];
      if (READ_ENA && count == '0) UNDFL <= 1'b1;
      MT   <= (count_n == '0);
      LAST <= (count_n <= LAST_LIM);
      FULL <= (count_n > FULL_LIM);
    end
  end

endmodule
